// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: operand/writeback/reservation bundle for the ID-stage register file.
//   master : ID/WB side (drives addresses, writeback, reservations; samples operands/flags)
//   slave  : register file (reg_file_sb)
// Signals:
//   RSaddr_i/RTaddr_i    read addresses        RSdata_o/RTdata_o  read data
//   RSbusy_o/RTbusy_o    pending-write flags   Pending_o          busy-register count
//   RDaddr_i/RDdata_i/RegWrite_i               writeback
//   Resv_i/Resvaddr_i                          destination reservation at issue
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RSaddr_i, RTaddr_i, RDaddr_i, Resvaddr_i;
  logic [DATA_W-1:0] RDdata_i, RSdata_o, RTdata_o;
  logic              RegWrite_i, Resv_i, RSbusy_o, RTbusy_o;
  logic [ADDR_W:0]   Pending_o;

  modport master (
    output RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Resv_i, Resvaddr_i,
    input  RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, Pending_o
  );
  modport slave (
    input  RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, Resv_i, Resvaddr_i,
    output RSdata_o, RTdata_o, RSbusy_o, RTbusy_o, Pending_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with per-register busy scoreboard.
//   Register 0 reads zero and ignores writes/reservations; register SP_IDX
//   resets to SP_INIT. Reads and busy flags are combinational; Pending_o is the
//   registered popcount of the busy vector after each edge.
// Ports:
//   clk_i  clock (rising edge)
//   rst_i  asynchronous active-low reset
//   bus    reg_file_sb_if.slave (reads, writeback, reservations, flags)
// Optional feature: define REGFILE_BYPASS_EN for same-cycle writeback-to-read
//   forwarding (data and busy flag).
module reg_file_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 31
) (
  input  logic         clk_i,
  input  logic         rst_i,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic [ADDR_W:0]              pend_nxt, pending;

  // Scoreboard next state; a reserve in the same cycle as the writeback wins
  // because the reserving instruction is the newer producer.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < DEPTH; r++) begin
      if (bus.Resv_i && bus.Resvaddr_i == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
      else if (bus.RegWrite_i && bus.RDaddr_i == ADDR_W'(r))
        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    pend_nxt = '0;
    for (int r = 0; r < DEPTH; r++)
      pend_nxt = pend_nxt + (ADDR_W+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < DEPTH; r++)
        regs[r] <= (r == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      if (bus.RegWrite_i && bus.RDaddr_i != '0)
        regs[bus.RDaddr_i] <= bus.RDdata_i;
      busy    <= busy_nxt;
      pending <= pend_nxt;
    end
  end

  logic [DATA_W-1:0] rs_arr, rt_arr;
  logic              rs_bsy, rt_bsy;

  assign rs_arr = (bus.RSaddr_i == '0) ? '0 : regs[bus.RSaddr_i];
  assign rt_arr = (bus.RTaddr_i == '0) ? '0 : regs[bus.RTaddr_i];
  assign rs_bsy = busy[bus.RSaddr_i];
  assign rt_bsy = busy[bus.RTaddr_i];

`ifdef REGFILE_BYPASS_EN
  logic wr_any, rs_fwd, rt_fwd, rs_resv, rt_resv;
  assign wr_any  = bus.RegWrite_i && bus.RDaddr_i != '0;
  assign rs_fwd  = wr_any && bus.RDaddr_i == bus.RSaddr_i;
  assign rt_fwd  = wr_any && bus.RDaddr_i == bus.RTaddr_i;
  // A same-cycle re-reservation keeps the old busy bit visible this cycle.
  assign rs_resv = bus.Resv_i && bus.Resvaddr_i == bus.RSaddr_i;
  assign rt_resv = bus.Resv_i && bus.Resvaddr_i == bus.RTaddr_i;

  assign bus.RSdata_o = rs_fwd ? bus.RDdata_i : rs_arr;
  assign bus.RTdata_o = rt_fwd ? bus.RDdata_i : rt_arr;
  assign bus.RSbusy_o = (rs_fwd && !rs_resv) ? 1'b0 : rs_bsy;
  assign bus.RTbusy_o = (rt_fwd && !rt_resv) ? 1'b0 : rt_bsy;
`else
  assign bus.RSdata_o = rs_arr;
  assign bus.RTdata_o = rt_arr;
  assign bus.RSbusy_o = rs_bsy;
  assign bus.RTbusy_o = rt_bsy;
`endif

  assign bus.Pending_o = pending;
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic clk = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_INIT(31)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty observed=%h required=<entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite_i = 1'b0;
    bus.Resv_i     = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.RSaddr_i   = '0;
    bus.RTaddr_i   = '0;
    bus.RDaddr_i   = '0;
    bus.RDdata_i   = '0;
    bus.Resvaddr_i = '0;
    idle();
    step(); step();
    rst_n = 1'b1;

    // Populate some state, then drop reset mid-clock while a write is pending.
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd5; bus.RDdata_i = 32'h1111_2222;
    bus.Resv_i = 1'b1; bus.Resvaddr_i = 5'd4;
    step();
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd6; bus.RDdata_i = 32'h0000_0777;
    bus.Resv_i = 1'b0;
    bus.RSaddr_i = 5'd5; bus.RTaddr_i = 5'd29;
    #3 rst_n = 1'b0;
    #1;
    sb_push("rst_rs5", 32'h0);          sb_check(bus.RSdata_o);
    sb_push("rst_sp", 32'd31);          sb_check(bus.RTdata_o);
    sb_push("rst_pending", 32'h0);      sb_check(32'(bus.Pending_o));
    bus.RSaddr_i = 5'd4;
    #1;
    sb_push("rst_busy4", 32'h0);        sb_check(32'(bus.RSbusy_o));
    step();                              // edge under reset: write to 6 discarded
    idle();
    rst_n = 1'b1;
    bus.RSaddr_i = 5'd6;
    #1;
    sb_push("rst_wr_discard", 32'h0);   sb_check(bus.RSdata_o);

    // Plain write and read-back; writeback to a non-busy register.
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd5; bus.RDdata_i = 32'hDEAD_BEEF;
    step();
    idle();
    bus.RSaddr_i = 5'd5; bus.RTaddr_i = 5'd0;
    #1;
    sb_push("rd_rs5", 32'hDEAD_BEEF);   sb_check(bus.RSdata_o);
    sb_push("rd_rs5_busy", 32'h0);      sb_check(32'(bus.RSbusy_o));
    sb_push("rd_rt0", 32'h0);           sb_check(bus.RTdata_o);

    // Register 0 ignores writes.
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd0; bus.RDdata_i = 32'h0000_1234;
    step();
    idle();
    bus.RSaddr_i = 5'd0;
    #1;
    sb_push("r0_data", 32'h0);          sb_check(bus.RSdata_o);
    sb_push("r0_busy", 32'h0);          sb_check(32'(bus.RSbusy_o));

    // Reserve 7, then write it back.
    bus.Resv_i = 1'b1; bus.Resvaddr_i = 5'd7;
    step();
    idle();
    bus.RTaddr_i = 5'd7;
    #1;
    sb_push("resv7_busy", 32'h1);       sb_check(32'(bus.RTbusy_o));
    sb_push("resv7_pend", 32'h1);       sb_check(32'(bus.Pending_o));
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd7; bus.RDdata_i = 32'h0000_0011;
    #1;
`ifdef REGFILE_BYPASS_EN
    sb_push("wb7_pre_busy", 32'h0);     sb_check(32'(bus.RTbusy_o));
    sb_push("wb7_pre_data", 32'h11);    sb_check(bus.RTdata_o);
`else
    sb_push("wb7_pre_busy", 32'h1);     sb_check(32'(bus.RTbusy_o));
    sb_push("wb7_pre_data", 32'h0);     sb_check(bus.RTdata_o);
`endif
    step();
    idle();
    #1;
    sb_push("wb7_busy", 32'h0);         sb_check(32'(bus.RTbusy_o));
    sb_push("wb7_pend", 32'h0);         sb_check(32'(bus.Pending_o));
    sb_push("wb7_data", 32'h11);        sb_check(bus.RTdata_o);

    // Same-cycle reserve and writeback of 9: data lands, new producer keeps busy.
    bus.Resv_i = 1'b1; bus.Resvaddr_i = 5'd9;
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd9; bus.RDdata_i = 32'h55;
    step();
    idle();
    bus.RSaddr_i = 5'd9;
    #1;
    sb_push("rw9_data", 32'h55);        sb_check(bus.RSdata_o);
    sb_push("rw9_busy", 32'h1);         sb_check(32'(bus.RSbusy_o));
    sb_push("rw9_pend", 32'h1);         sb_check(32'(bus.Pending_o));

    // Forwarding window on register 3.
    bus.Resv_i = 1'b1; bus.Resvaddr_i = 5'd3;
    step();
    idle();
    bus.RSaddr_i = 5'd3;
    #1;
    sb_push("r3_pend", 32'h2);          sb_check(32'(bus.Pending_o));
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd3; bus.RDdata_i = 32'h0000_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    sb_push("byp_data", 32'hA5A5);      sb_check(bus.RSdata_o);
    sb_push("byp_busy", 32'h0);         sb_check(32'(bus.RSbusy_o));
`else
    sb_push("byp_data", 32'h0);         sb_check(bus.RSdata_o);
    sb_push("byp_busy", 32'h1);         sb_check(32'(bus.RSbusy_o));
`endif
    step();
    idle();
    #1;
    sb_push("r3_data", 32'hA5A5);       sb_check(bus.RSdata_o);
    sb_push("r3_busy", 32'h0);          sb_check(32'(bus.RSbusy_o));
    sb_push("r3_pend_after", 32'h1);    sb_check(32'(bus.Pending_o));

    // Retire 9, then reserve every nonzero register one per cycle.
    bus.RegWrite_i = 1'b1; bus.RDaddr_i = 5'd9; bus.RDdata_i = 32'h66;
    step();
    idle();
    #1;
    sb_push("clr9_pend", 32'h0);        sb_check(32'(bus.Pending_o));
    for (int i = 1; i < 32; i++) begin
      bus.Resv_i = 1'b1; bus.Resvaddr_i = 5'(i);
      step();
      sb_push($sformatf("fill_pend_%0d", i), 32'(i));
      sb_check(32'(bus.Pending_o));
    end
    // Re-reserving an already-busy register keeps the count.
    bus.Resvaddr_i = 5'd12;
    step();
    sb_push("rresv_pend", 32'd31);      sb_check(32'(bus.Pending_o));
    bus.Resvaddr_i = 5'd0;
    step();
    idle();
    bus.RSaddr_i = 5'd0; bus.RTaddr_i = 5'd31;
    #1;
    sb_push("resv0_pend", 32'd31);      sb_check(32'(bus.Pending_o));
    sb_push("resv0_busy", 32'h0);       sb_check(32'(bus.RSbusy_o));
    sb_push("r31_busy", 32'h1);         sb_check(32'(bus.RTbusy_o));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover observed=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
